// File: rtl/mmu_pkg.sv
// Shared constants and lane-slicing helper for the matrix-multiply unit.
package mmu_pkg;

    localparam int VAR_SIZE = 8;
    localparam int ACC_SIZE = 32;
    localparam int MMU_SIZE = 10;

    // Bit offset of lane idx inside a flattened vector of width-bit lanes.
    function automatic int lane(input int idx, input int width = VAR_SIZE);
        return width * idx;
    endfunction

endpackage

// File: rtl/mmu_skew_buffer_if.sv
// Flattened lane vectors entering and leaving the skew buffer.
interface mmu_skew_buffer_if #(
    parameter int VAR_SIZE = mmu_pkg::VAR_SIZE,
    parameter int MMU_SIZE = mmu_pkg::MMU_SIZE
);

    logic [VAR_SIZE*MMU_SIZE-1:0] A1;
    logic [VAR_SIZE*MMU_SIZE-1:0] B1;

    modport master (output A1, input B1);
    modport slave  (input A1, output B1);

endinterface

// File: rtl/mmu_delay_line.sv
// Fixed-depth shift register with asynchronous clear.
module mmu_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                stage[j] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int j = 1; j < DEPTH; j++) begin
                stage[j] <= stage[j-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/mmu_skew_buffer.sv
// Per-lane staggered delay: skews vectors into the array or de-skews results out.
module mmu_skew_buffer #(
    parameter int VAR_SIZE = mmu_pkg::VAR_SIZE,
    parameter int MMU_SIZE = mmu_pkg::MMU_SIZE,
    parameter bit REVERSED = 1'b0
) (
    input logic              clk,
    input logic              rst_n,
    mmu_skew_buffer_if.slave bus
);

    import mmu_pkg::lane;

    logic [VAR_SIZE*MMU_SIZE-1:0] b_flat;

    // Skew grows with lane index; de-skew mirrors it so the sum is MMU_SIZE+1.
    for (genvar i = 0; i < MMU_SIZE; i++) begin : g_lane
        localparam int DEPTH = REVERSED ? MMU_SIZE - i : i + 1;

        mmu_delay_line #(
            .WIDTH (VAR_SIZE),
            .DEPTH (DEPTH)
        ) u_line (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (bus.A1[lane(i, VAR_SIZE) +: VAR_SIZE]),
            .q     (b_flat[lane(i, VAR_SIZE) +: VAR_SIZE])
        );
    end

    assign bus.B1 = b_flat;

endmodule

// File: tb/tb_mmu_skew_buffer.sv
// Randomised bench for mmu_skew_buffer against a queue-based delay model.
module tb_mmu_skew_buffer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] a8 = '0;
    logic [127:0] aw = '0;

    int checks = 0;
    int failures = 0;

    logic [31:0] hist[$];
    logic [127:0] whist[$];

    logic [31:0] lit_fwd_rel[4] = '{32'h00000001, 32'h00000201,
                                    32'h00030201, 32'h04030201};
    logic [31:0] lit_rev_rel[4] = '{32'h04000000, 32'h04030000,
                                    32'h04030200, 32'h04030201};
    logic [31:0] lit_fwd_imp[5] = '{32'h00000001, 32'h00000100,
                                    32'h00010000, 32'h01000000, 32'h0};
    logic [31:0] lit_rev_imp[5] = '{32'h01000000, 32'h00010000,
                                    32'h00000100, 32'h00000001, 32'h0};

    always #5 clk = ~clk;

    mmu_skew_buffer_if #(.VAR_SIZE(8),  .MMU_SIZE(4)) fwd_if ();
    mmu_skew_buffer_if #(.VAR_SIZE(8),  .MMU_SIZE(4)) rev_if ();
    mmu_skew_buffer_if #(.VAR_SIZE(8),  .MMU_SIZE(4)) chain_if ();
    mmu_skew_buffer_if #(.VAR_SIZE(32), .MMU_SIZE(4)) wide_if ();
    mmu_skew_buffer_if #(.VAR_SIZE(8),  .MMU_SIZE(1)) one_if ();

    assign fwd_if.A1   = a8;
    assign rev_if.A1   = a8;
    assign chain_if.A1 = fwd_if.B1;
    assign wide_if.A1  = aw;
    assign one_if.A1   = a8[7:0];

    mmu_skew_buffer #(.VAR_SIZE(8), .MMU_SIZE(4), .REVERSED(1'b0)) u_fwd (
        .clk(clk), .rst_n(rst_n), .bus(fwd_if.slave));
    mmu_skew_buffer #(.VAR_SIZE(8), .MMU_SIZE(4), .REVERSED(1'b1)) u_rev (
        .clk(clk), .rst_n(rst_n), .bus(rev_if.slave));
    mmu_skew_buffer #(.VAR_SIZE(8), .MMU_SIZE(4), .REVERSED(1'b1)) u_chain (
        .clk(clk), .rst_n(rst_n), .bus(chain_if.slave));
    mmu_skew_buffer #(.VAR_SIZE(32), .MMU_SIZE(4), .REVERSED(1'b0)) u_wide (
        .clk(clk), .rst_n(rst_n), .bus(wide_if.slave));
    mmu_skew_buffer #(.VAR_SIZE(8), .MMU_SIZE(1), .REVERSED(1'b1)) u_one (
        .clk(clk), .rst_n(rst_n), .bus(one_if.slave));

    // Model: every captured input since the last reset, newest at the back.
    always @(negedge rst_n) begin
        hist.delete();
        whist.delete();
    end

    always @(posedge clk) begin
        if (!rst_n) begin
            hist.delete();
            whist.delete();
        end else begin
            hist.push_back(a8);
            whist.push_back(aw);
            if (hist.size() > 8) void'(hist.pop_front());
            if (whist.size() > 8) void'(whist.pop_front());
        end
    end

    function automatic logic [7:0] h8(input int d, input int i);
        logic [31:0] v;
        if (hist.size() < d) return 8'h00;
        v = hist[hist.size() - d];
        return v[8*i +: 8];
    endfunction

    function automatic logic [31:0] hw(input int d, input int i);
        logic [127:0] v;
        if (whist.size() < d) return 32'h0;
        v = whist[whist.size() - d];
        return v[32*i +: 32];
    endfunction

    task automatic check(input string name, input logic [127:0] act,
                         input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        logic [31:0] ef, er, ec;
        logic [127:0] ew;
        for (int i = 0; i < 4; i++) begin
            ef[8*i +: 8]   = h8(i + 1, i);
            er[8*i +: 8]   = h8(4 - i, i);
            ec[8*i +: 8]   = h8(5, i);
            ew[32*i +: 32] = hw(i + 1, i);
        end
        check("model_fwd", {96'h0, fwd_if.B1}, {96'h0, ef});
        check("model_rev", {96'h0, rev_if.B1}, {96'h0, er});
        check("model_chain", {96'h0, chain_if.B1}, {96'h0, ec});
        check("model_wide", wide_if.B1, ew);
        check("model_one", {120'h0, one_if.B1}, {120'h0, h8(1, 0)});
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        a8 = 32'h04030201;
        repeat (3) begin
            tick();
            check("rst_fwd", {96'h0, fwd_if.B1}, 128'h0);
            check("rst_rev", {96'h0, rev_if.B1}, 128'h0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("rel_fwd", {96'h0, fwd_if.B1}, {96'h0, lit_fwd_rel[k]});
            check("rel_rev", {96'h0, rev_if.B1}, {96'h0, lit_rev_rel[k]});
        end
        a8 = '0;
        repeat (6) tick();

        a8 = 32'h01010101;
        for (int e = 0; e < 5; e++) begin
            tick();
            a8 = '0;
            check("imp_fwd", {96'h0, fwd_if.B1}, {96'h0, lit_fwd_imp[e]});
            check("imp_rev", {96'h0, rev_if.B1}, {96'h0, lit_rev_imp[e]});
        end
        repeat (6) tick();

        for (int c = 0; c < 4; c++) begin
            a8 = {8'(12 + c), 8'(8 + c), 8'(4 + c), 8'(c)};
            tick();
        end
        check("wave_fwd", {96'h0, fwd_if.B1}, 128'h0C090603);
        a8 = '0;
        tick();
        check("align_chain", {96'h0, chain_if.B1}, 128'h0C080400);
        repeat (6) tick();

        a8 = 32'h00FF7F80;
        aw = {4{32'h80000001}};
        tick();
        a8 = '0;
        aw = '0;
        tick();
        check("signed_l1", {120'h0, fwd_if.B1[15:8]}, 128'h7F);
        repeat (6) tick();

        for (int n = 0; n < 300; n++) begin
            tick();
            a8 = $urandom;
            aw = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 24) == 0) begin
                rst_n = 1'b0;
                #1;
                check("async_fwd", {96'h0, fwd_if.B1}, 128'h0);
                check("async_chain", {96'h0, chain_if.B1}, 128'h0);
                check("async_wide", wide_if.B1, 128'h0);
                @(negedge clk);
                #1 rst_n = 1'b1;
            end
        end

        tick();
        rst_n = 1'b0;
        #1;
        check("async_rev", {96'h0, rev_if.B1}, 128'h0);
        check("async_one", {120'h0, one_if.B1}, 128'h0);
        #2 rst_n = 1'b1;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
